seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised successor to the fixed 8-digit scanner. Drives an N_DIG-digit multiplexed common-anode 7-segment display from one binary value.
- Performs binary-to-BCD conversion sequentially (shift-add-3), commits results atomically, scans digits at a programmable rate.
- Adds leading-zero blanking, a per-digit enable mask, a decimal-point mask and overflow indication.
- Sits between the control FSM (temperature/power/charge values) and board pins DIG/Y.

Parameters:
- N_DIG, 8, number of digits scanned (1..8).
- VAL_W, 10, width of binary input value.
- SCAN_DIV, 100000, clk cycles per digit slot (≥2).
- LZ_SUPPRESS, 1, 1 = blank leading zeros (digit 0 always lit).
- BLINK_DIV, 25, scan frames per blink half-period (used only with DISP_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- value_i  in  VAL_W  binary value to display.
- load  in  1  one-cycle request to convert value_i.
- busy  out  1  conversion in progress; load ignored while high.
- en_mask  in  N_DIG  per-digit enable; 0 = digit dark.
- dp_mask  in  N_DIG  per-digit decimal point; 1 = dot lit.
- blink_mask  in  N_DIG  per-digit blink request.
- ovf  out  1  last committed value exceeded 10^N_DIG−1.
- DIG  out  N_DIG  digit select, active-low, one-hot-low or all-ones.
- Y  out  8  {dp, g,f,e,d,c,b,a}, all active-low.

Behaviour:
- Reset (rst=0, async): DIG all ones, Y=8'hFF, busy=0, ovf=0. BCD display register cleared to zero. Prescaler, scan index and blink phase cleared.
- Prescaler counts 0..SCAN_DIV−1. Tick on terminal count, then wraps to 0.
- Scan index advances on tick, 0..N_DIG−1, and wraps to 0. Digit 0 is least significant and maps to DIG[0].
- Converter FSM states IDLE → SHIFT → COMMIT → IDLE.
  - IDLE: load=1 captures value_i, busy goes high next cycle.
  - SHIFT: exactly VAL_W cycles of add-3-then-shift on a 4·N_DIG-bit BCD accumulator.
  - COMMIT: one cycle. Writes the display register and ovf, busy drops.
  - Latency: load to new digits visible = VAL_W+2 cycles.
- load during busy is dropped, with no queuing. load and reset asserted together: reset wins.
- Overflow: if the captured value > 10^N_DIG−1, COMMIT sets ovf=1 and every enabled digit shows a dash (segment g only). The BCD digits are discarded. Otherwise ovf=0.
- The display register changes only in COMMIT, so a scan frame never shows a mix of old and new digits.
- Segment code gfedcba, active-high before inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes for 7 and 9 are corrected from the legacy table.
- Digit dark (DIG bit 1, Y=FF) when any of these holds:
  - en_mask bit = 0;
  - LZ_SUPPRESS and the digit is above the highest non-zero digit and is not digit 0;
  - blink off-phase.
- Dark digits also suppress dp.
- Outputs are registered. DIG and Y update in the same cycle, one cycle after the tick.
- Mask inputs are sampled live each slot; no latching.

Optional Feature:
- Macro DISP_BLINK_EN.
- Defined: a frame counter counts completed scans (index wrap) modulo BLINK_DIV and toggles the blink phase. Digits with blink_mask=1 go dark during the off phase. Phase resets to on.
- Undefined: blink_mask is ignored, the counter is not built, and digits follow en_mask/LZ rules only. The port remains so the interface is stable.

Decomposition:
- Package disp_pkg holds:
  - SEG_* constants (digits 0–9, SEG_DASH=7'b1000000, SEG_BLANK);
  - function bcd_to_seg;
  - function pow10_minus1(N) for the overflow limit;
  - the converter state enum.
- Sub-module bin2bcd_seq (parameters VAL_W, N_DIG), carrying the load/busy/done handshake and BCD output. seg_scan_display instantiates it plus the scan/mux logic.

Test Plan:
- Bench parameters: N_DIG=4, VAL_W=14, SCAN_DIV=4, BLINK_DIV=2, all masks 1 unless noted.
- Reset held low 10 cycles, then released: DIG=4'hF and Y=8'hFF until the first tick. The first frame shows "0" on digit 0 only; digits 1–3 dark (LZ).
- load with value_i=1234: busy high for 15 cycles, then the frame shows Y low-7 = ~1234's codes on DIG[3..0]. ovf=0.
- load 0042, then load 9999 asserted 3 cycles later (while busy): the second load is dropped and the display shows "42" with digits 2–3 dark.
- load 12000: ovf=1 and all four digits show dash (Y=8'hBF). dp_mask=4'b0100 gives Y=8'h3F on digit 2 only.
- With DISP_BLINK_EN, blink_mask=4'b0001, value 5678: digit 0 is dark on alternating 2-frame periods, digits 1–3 are steady. Without the macro, digit 0 is always lit.
- Assert rst mid-SHIFT: busy=0 immediately (async). After release, the display shows 0 and no stale commit occurs.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants, segment decoding and converter state type for the
// multiplexed 7-segment display scanner.
package disp_pkg;

  // Segment patterns gfedcba, active-high before inversion
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Largest value representable in n decimal digits
  function automatic longint unsigned pow10_minus1(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with load/busy/done handshake;
// bcd/ovf are registered and valid in the cycle done pulses.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int unsigned VAL_W = 10,
  parameter int unsigned N_DIG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VAL_W-1:0]     value_i,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_DIG-1:0]   bcd,
  output logic                 ovf
);

  localparam int unsigned BCD_W = 4 * N_DIG;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);
  localparam longint unsigned LIMIT = pow10_minus1(N_DIG);

  conv_state_e        state;
  logic [VAL_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj_c;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_cap;

  // Add 3 to every BCD digit that is 5 or more before the next shift
  always_comb begin
    acc_adj_c = acc;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CONV_IDLE;
      bin_sr  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      ovf_cap <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CONV_IDLE: begin
          if (load) begin
            bin_sr  <= value_i;
            acc     <= '0;
            bit_cnt <= '0;
            ovf_cap <= (64'(value_i) > LIMIT);
            busy    <= 1'b1;
            state   <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {acc, bin_sr} <= {acc_adj_c[BCD_W-2:0], bin_sr, 1'b0};
          bit_cnt       <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(VAL_W - 1)) state <= CONV_COMMIT;
        end
        CONV_COMMIT: begin
          // Overflowed digits are meaningless; present zeros instead
          bcd   <= ovf_cap ? '0 : acc;
          ovf   <= ovf_cap;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// N_DIG-digit multiplexed common-anode 7-segment scanner fed by a binary value.
// Optional macro DISP_BLINK_EN builds the per-digit blink frame counter.
module seg_scan_display
  import disp_pkg::*;
#(
  parameter int unsigned N_DIG       = 8,
  parameter int unsigned VAL_W       = 10,
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned LZ_SUPPRESS = 1,
  parameter int unsigned BLINK_DIV   = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  value_i,
  input  logic              load,
  output logic              busy,
  input  logic [N_DIG-1:0]  en_mask,
  input  logic [N_DIG-1:0]  dp_mask,
  input  logic [N_DIG-1:0]  blink_mask,
  output logic              ovf,
  output logic [N_DIG-1:0]  DIG,
  output logic [7:0]        Y
);

  localparam int unsigned BCD_W = 4 * N_DIG;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_ovf;

  bin2bcd_seq #(
    .VAL_W (VAL_W),
    .N_DIG (N_DIG)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .value_i (value_i),
    .load    (load),
    .busy    (busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .ovf     (conv_ovf)
  );

  // Display register: written only on commit so a frame never mixes values
  logic [BCD_W-1:0] disp_bcd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_bcd <= '0;
      ovf      <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      ovf      <= conv_ovf;
    end
  end

  logic [PRE_W-1:0] pre_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic             tick_c;
  logic             last_slot_c;

  assign tick_c      = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign last_slot_c = (scan_idx == IDX_W'(N_DIG - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
      if (tick_c) scan_idx <= last_slot_c ? '0 : scan_idx + IDX_W'(1);
    end
  end

  logic blink_dark_c;

`ifdef DISP_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] frame_cnt;
  logic             blink_off;

  // Phase flips every BLINK_DIV completed frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (tick_c && last_slot_c) begin
      if (frame_cnt == BLK_W'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + BLK_W'(1);
      end
    end
  end

  assign blink_dark_c = blink_off & blink_mask[scan_idx];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 32'(BLINK_DIV)};
  assign blink_dark_c = 1'b0;
`endif

  logic [N_DIG-1:0] lz_dark_c;
  logic [3:0]       cur_bcd_c;
  logic [6:0]       seg_c;
  logic             dark_c;

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    logic zero_above;
    lz_dark_c  = '0;
    zero_above = 1'b1;
    for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
      zero_above   = zero_above & (disp_bcd[4*i +: 4] == 4'd0);
      lz_dark_c[i] = (LZ_SUPPRESS != 0) && (i != 0) && zero_above;
    end
  end

  always_comb begin
    cur_bcd_c = 4'd0;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (scan_idx == IDX_W'(i)) cur_bcd_c = disp_bcd[4*i +: 4];
    end
    seg_c  = ovf ? SEG_DASH : bcd_to_seg(cur_bcd_c);
    dark_c = !en_mask[scan_idx] || (!ovf && lz_dark_c[scan_idx]) || blink_dark_c;
  end

  // Pins update together in the cycle after each tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DIG <= '1;
      Y   <= 8'hFF;
    end else if (tick_c) begin
      if (dark_c) begin
        DIG <= '1;
        Y   <= 8'hFF;
      end else begin
        DIG <= ~(N_DIG'(1) << scan_idx);
        Y   <= ~{dp_mask[scan_idx], seg_c};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display against a decimal-arithmetic display model.
module tb_seg_scan_display;

  localparam int N_DIG     = 4;
  localparam int VAL_W     = 14;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int MAX_DEC   = 9999;

  logic             clk;
  logic             rst;
  logic [VAL_W-1:0] value_i;
  logic             load;
  logic             busy;
  logic [N_DIG-1:0] en_mask;
  logic [N_DIG-1:0] dp_mask;
  logic [N_DIG-1:0] blink_mask;
  logic             ovf;
  logic [N_DIG-1:0] DIG;
  logic [7:0]       Y;

  seg_scan_display #(
    .N_DIG       (N_DIG),
    .VAL_W       (VAL_W),
    .SCAN_DIV    (SCAN_DIV),
    .LZ_SUPPRESS (1),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .load       (load),
    .busy       (busy),
    .en_mask    (en_mask),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .ovf        (ovf),
    .DIG        (DIG),
    .Y          (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: edge count since reset release and committed value
  int n, pend_edge, pend_val, next_accept, busy_last, model_val;
  logic model_ovf;
  logic [N_DIG-1:0] exp_dig;
  logic [7:0]       exp_y;
  logic             exp_busy, exp_ovf;

  function automatic int p10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  task automatic model_reset();
    n = 0; pend_edge = -1; pend_val = 0; next_accept = 0; busy_last = -1;
    model_val = 0; model_ovf = 1'b0;
    exp_dig = '1; exp_y = 8'hFF; exp_busy = 1'b0; exp_ovf = 1'b0;
  endtask

  // Advance one clock and update the expected pin values
  task automatic step();
    int s, idx, f, dg;
    logic dark;
    logic [6:0] seg;
    @(posedge clk);
    n++;
    if (n % SCAN_DIV == 0) begin
      s   = n / SCAN_DIV - 1;
      idx = s % N_DIG;
      f   = s / N_DIG;
      dg  = (model_val / p10(idx)) % 10;
      dark = !en_mask[idx] || (!model_ovf && idx != 0 && model_val < p10(idx));
`ifdef DISP_BLINK_EN
      if (blink_mask[idx] && ((f / BLINK_DIV) % 2 == 1)) dark = 1'b1;
`endif
      seg = model_ovf ? 7'h40 : seg_tab[dg];
      exp_dig = dark ? 4'hF : ~(4'b0001 << idx);
      exp_y   = dark ? 8'hFF : ~{dp_mask[idx], seg};
    end
    if (n == pend_edge) begin
      model_ovf = (pend_val > MAX_DEC);
      model_val = model_ovf ? 0 : pend_val;
    end
    if (load && n >= next_accept) begin
      pend_val    = int'(value_i);
      pend_edge   = n + VAL_W + 2;
      next_accept = n + VAL_W + 2;
      busy_last   = n + VAL_W;
    end
    exp_busy = (n <= busy_last);
    exp_ovf  = model_ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; value_i = '0;
    en_mask = '1; dp_mask = '0; blink_mask = '0;
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (DIG !== 4'hF || Y !== 8'hFF || busy !== 1'b0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got DIG=%h Y=%h busy=%b ovf=%b, want F FF 0 0", DIG, Y, busy, ovf);
      end
    end
    rst = 1'b1;
    model_reset();
    repeat (2 * N_DIG * SCAN_DIV) begin
      step();
      n_cmp++;
      if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL first_frame n=%0d: got DIG=%h Y=%h busy=%b ovf=%b, want DIG=%h Y=%h busy=%b ovf=%b",
                 n, DIG, Y, busy, ovf, exp_dig, exp_y, exp_busy, exp_ovf);
      end
    end
  endtask

  task automatic test_convert(input int v, input logic [N_DIG-1:0] dpm, input int cycles);
    int busy_cnt = 0;
    dp_mask = dpm;
    value_i = VAL_W'(v); load = 1'b1;
    step();
    load = 1'b0;
    if (busy) busy_cnt++;
    repeat (cycles) begin
      step();
      if (busy) busy_cnt++;
      n_cmp++;
      if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL convert_%0d n=%0d: got DIG=%h Y=%h busy=%b ovf=%b, want DIG=%h Y=%h busy=%b ovf=%b",
                 v, n, DIG, Y, busy, ovf, exp_dig, exp_y, exp_busy, exp_ovf);
      end
    end
    n_cmp++;
    if (busy_cnt != VAL_W + 1) begin
      n_fail++;
      $display("FAIL busy_len_%0d: got %0d cycles, want %0d", v, busy_cnt, VAL_W + 1);
    end
  endtask

  task automatic test_dropped_load();
    dp_mask = '0;
    value_i = VAL_W'(42); load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    value_i = VAL_W'(9999); load = 1'b1;
    step();
    load = 1'b0;
    repeat (3 * N_DIG * SCAN_DIV) begin
      step();
      n_cmp++;
      if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL dropped_load n=%0d: got DIG=%h Y=%h busy=%b ovf=%b, want DIG=%h Y=%h busy=%b ovf=%b",
                 n, DIG, Y, busy, ovf, exp_dig, exp_y, exp_busy, exp_ovf);
      end
    end
  endtask

  task automatic test_blink();
    dp_mask = '0; blink_mask = 4'b0001;
    value_i = VAL_W'(5678); load = 1'b1;
    step();
    load = 1'b0;
    repeat (10 * N_DIG * SCAN_DIV) begin
      step();
      n_cmp++;
      if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL blink n=%0d: got DIG=%h Y=%h, want DIG=%h Y=%h", n, DIG, Y, exp_dig, exp_y);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      en_mask    = N_DIG'($urandom_range(15, 0) | (($urandom_range(1, 0) != 0) ? 15 : 0));
      dp_mask    = N_DIG'($urandom_range(15, 0));
      blink_mask = N_DIG'($urandom_range(15, 0));
      value_i    = VAL_W'($urandom_range(16383, 0));
      load       = 1'b1;
      step();
      load = 1'b0;
      repeat ($urandom_range(70, 20)) begin
        if ($urandom_range(7, 0) == 0) begin
          value_i = VAL_W'($urandom_range(16383, 0));
          load    = 1'b1;
        end
        step();
        load = 1'b0;
        n_cmp++;
        if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL random_%0d n=%0d: got DIG=%h Y=%h busy=%b ovf=%b, want DIG=%h Y=%h busy=%b ovf=%b",
                   it, n, DIG, Y, busy, ovf, exp_dig, exp_y, exp_busy, exp_ovf);
        end
      end
    end
    en_mask = '1; dp_mask = '0; blink_mask = '0;
  endtask

  task automatic test_reset_mid_shift();
    value_i = VAL_W'(777); load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    rst  = 1'b0;
    load = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || DIG !== 4'hF || Y !== 8'hFF || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b DIG=%h Y=%h ovf=%b, want 0 F FF 0", busy, DIG, Y, ovf);
    end
    repeat (3) @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;
    model_reset();
    repeat (3 * N_DIG * SCAN_DIV) begin
      step();
      n_cmp++;
      if (DIG !== exp_dig || Y !== exp_y || busy !== exp_busy || ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL post_reset n=%0d: got DIG=%h Y=%h busy=%b ovf=%b, want DIG=%h Y=%h busy=%b ovf=%b",
                 n, DIG, Y, busy, ovf, exp_dig, exp_y, exp_busy, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert(1234, 4'b0000, 3 * N_DIG * SCAN_DIV);
    test_dropped_load();
    test_convert(12000, 4'b0100, 3 * N_DIG * SCAN_DIV);
    test_convert(0, 4'b1010, 3 * N_DIG * SCAN_DIV);
    test_convert(9999, 4'b0000, 3 * N_DIG * SCAN_DIV);
    test_convert(10000, 4'b0000, 3 * N_DIG * SCAN_DIV);
    test_blink();
    test_random();
    test_convert(305, 4'b0001, 3 * N_DIG * SCAN_DIV);
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
